// File: rtl/dm_stage.sv
// Data-memory / writeback stage: sub-word loads and stores with sign/zero extension,
// misalignment faulting, configurable access latency and the final writeback select.
module dm_stage #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int WAIT   = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Valid,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  input  logic [31:0] nextPC,
  output logic        Ready,
  output logic        Done,
  output logic [31:0] Wdata,
  output logic        Fault
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_JAL = 6'h03;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;

  logic [5:0]        op_p0;
  logic [31:0]       res_p0;
  logic [31:0]       st_p0;
  logic [31:0]       npc_p0;
  logic [31:0]       mem [DEPTH];

  logic [5:0]        cur_op;
  logic [31:0]       cur_res;
  logic [31:0]       cur_st;
  logic [31:0]       cur_npc;
  logic [ADDR_W-1:0] widx;
  logic [1:0]        lane;
  logic [31:0]       rd_word;
  logic [31:0]       wb_val;
  logic              cur_load, cur_store, cur_mis;
  logic              accept, enter_resp;
  logic              unused_ins;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] ln);
    logic half, word;
    half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    word = (op == OP_LW) || (op == OP_SW);
    return (half && ln[0]) || (word && (ln != 2'b00));
  endfunction

  function automatic logic [31:0] ld_extract(input logic [5:0] op, input logic [31:0] w,
                                             input logic [1:0] ln);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = w[{ln, 3'b000} +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:   r = 32'(b);
      OP_LH:   r = 32'(h);
      OP_LBU:  r = {24'd0, b};
      OP_LHU:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] st_merge(input logic [5:0] op, input logic [31:0] old,
                                           input logic [31:0] d, input logic [1:0] ln);
    logic [31:0] r;
    r = old;
    case (op)
      OP_SB: r[{ln, 3'b000} +: 8] = d[7:0];
      OP_SH: if (ln[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  // In IDLE the live inputs describe the op; once accepted the captured copy does.
  always_comb begin
    if (state == S_IDLE) begin
      cur_op  = Ins[31:26];
      cur_res = Result;
      cur_st  = Rdata2;
      cur_npc = nextPC;
    end else begin
      cur_op  = op_p0;
      cur_res = res_p0;
      cur_st  = st_p0;
      cur_npc = npc_p0;
    end
  end

  assign widx       = cur_res[ADDR_W+1:2];
  assign lane       = cur_res[1:0];
  assign rd_word    = mem[widx];
  assign cur_load   = is_load(cur_op);
  assign cur_store  = is_store(cur_op);
  assign cur_mis    = misaligned(cur_op, lane);
  assign accept     = (state == S_IDLE) && Valid;
  assign enter_resp = (state_nxt == S_RESP);
  assign Ready      = (state == S_IDLE);
  assign Done       = (state == S_RESP);
  assign unused_ins = ^Ins[25:0];

  always_comb begin
    wb_val = cur_res;
    if (cur_mis || cur_store)  wb_val = '0;
    else if (cur_load)         wb_val = ld_extract(cur_op, rd_word, lane);
    else if (cur_op == OP_JAL) wb_val = cur_npc;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (Valid) begin
          if ((is_load(Ins[31:26]) || is_store(Ins[31:26])) && (WAIT > 0)) begin
            state_nxt = S_BUSY;
            cnt_nxt   = 4'(WAIT - 1);
          end else begin
            state_nxt = S_RESP;
          end
        end
      end
      S_BUSY: begin
        if (cnt == 4'd0) state_nxt = S_RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: operand capture at the accept edge
  always_ff @(posedge CLK) begin
    if (accept) begin
      op_p0  <= Ins[31:26];
      res_p0 <= Result;
      st_p0  <= Rdata2;
      npc_p0 <= nextPC;
    end
  end

  // Response: memory update and writeback sample happen on the edge entering RESP
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      Wdata <= '0;
      Fault <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (enter_resp) begin
        Wdata <= wb_val;
        Fault <= cur_mis;
      end else if (state == S_RESP) begin
        Fault <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enter_resp && cur_store && !cur_mis) begin
      mem[widx] <= st_merge(cur_op, rd_word, cur_st, lane);
    end
  end

endmodule

// File: tb/tb_dm_stage.sv
// Bench for dm_stage: two instances (WAIT=3 and WAIT=0) checked against a byte-addressed
// memory model with directed steps followed by randomized operations.
module tb_dm_stage;

  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B, JAL = 6'h03, BEQ = 6'h04;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid  [2];
  logic [31:0] ins    [2];
  logic [31:0] result [2];
  logic [31:0] rdata2 [2];
  logic [31:0] npc    [2];
  logic        ready  [2];
  logic        done   [2];
  logic        fault  [2];
  logic [31:0] wdata  [2];

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [7:0]  mbytes [2][256];
  logic [31:0] last_w [2];

  always #5 clk = ~clk;

  dm_stage #(.DEPTH(64), .ADDR_W(6), .WAIT(3)) u_dut0 (
    .CLK(clk), .RST(rst), .Valid(valid[0]), .Ins(ins[0]), .Result(result[0]),
    .Rdata2(rdata2[0]), .nextPC(npc[0]), .Ready(ready[0]), .Done(done[0]),
    .Wdata(wdata[0]), .Fault(fault[0])
  );

  dm_stage #(.DEPTH(64), .ADDR_W(6), .WAIT(0)) u_dut1 (
    .CLK(clk), .RST(rst), .Valid(valid[1]), .Ins(ins[1]), .Result(result[1]),
    .Rdata2(rdata2[1]), .nextPC(npc[1]), .Ready(ready[1]), .Done(done[1]),
    .Wdata(wdata[1]), .Fault(fault[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mem(input logic [5:0] op);
    return op inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) mbytes[d][i] = 8'h00;
      last_w[d] = 32'h0;
    end
  endtask

  // 64 words = 256 bytes, so the low 8 address bits pick the byte and everything wraps.
  task automatic model_op(input int d, input logic [5:0] op, input logic [31:0] res,
                          input logic [31:0] rd2, input logic [31:0] np,
                          output logic [31:0] w, output logic f);
    int a;
    logic [15:0] h;
    a = int'(res[7:0]);
    f = ((op == LH || op == LHU || op == SH) && res[0]) ||
        ((op == LW || op == SW) && (res[1:0] != 2'b00));
    w = res;
    if (f) begin
      w = 32'h0;
    end else begin
      h = {mbytes[d][(a + 1) % 256], mbytes[d][a]};
      case (op)
        LB:  w = {{24{mbytes[d][a][7]}}, mbytes[d][a]};
        LBU: w = {24'h0, mbytes[d][a]};
        LH:  w = {{16{h[15]}}, h};
        LHU: w = {16'h0, h};
        LW:  w = {mbytes[d][a + 3], mbytes[d][a + 2], mbytes[d][a + 1], mbytes[d][a]};
        SB:  begin mbytes[d][a] = rd2[7:0]; w = 32'h0; end
        SH:  begin mbytes[d][a] = rd2[7:0]; mbytes[d][a + 1] = rd2[15:8]; w = 32'h0; end
        SW:  begin
          mbytes[d][a] = rd2[7:0];       mbytes[d][a + 1] = rd2[15:8];
          mbytes[d][a + 2] = rd2[23:16]; mbytes[d][a + 3] = rd2[31:24];
          w = 32'h0;
        end
        JAL: w = np;
        default: w = res;
      endcase
    end
    last_w[d] = w;
  endtask

  task automatic issue(input int d, input logic [5:0] op, input logic [31:0] res,
                       input logic [31:0] rd2, input logic [31:0] np, input bit hold,
                       input string tag);
    int lat;
    int elat;
    logic [31:0] ew;
    logic [31:0] prev;
    logic ef;
    @(negedge clk);
    lat = 0;
    while (ready[d] !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
    chk({tag, ".ready"}, 32'(ready[d]), 32'd1);
    valid[d]  = 1'b1;
    ins[d]    = {op, 26'($urandom)};
    result[d] = res;
    rdata2[d] = rd2;
    npc[d]    = np;
    prev = last_w[d];
    model_op(d, op, res, rd2, np, ew, ef);
    elat = (is_mem(op) && d == 0) ? 4 : 1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk({tag, ".busy"}, 32'(ready[d]), 32'd0);
        valid[d]  = hold;
        ins[d]    = $urandom;
        result[d] = $urandom;
        rdata2[d] = $urandom;
        npc[d]    = $urandom;
      end
      if (done[d] !== 1'b1 && lat < 40) begin
        chk({tag, ".hold_wdata"}, wdata[d], prev);
        chk({tag, ".idle_fault"}, 32'(fault[d]), 32'd0);
      end
    end while (done[d] !== 1'b1 && lat < 40);
    valid[d] = 1'b0;
    chk({tag, ".done"}, 32'(done[d]), 32'd1);
    chk({tag, ".latency"}, 32'(lat), 32'(elat));
    chk({tag, ".wdata"}, wdata[d], ew);
    chk({tag, ".fault"}, 32'(fault[d]), 32'(ef));
  endtask

  task automatic rand_op(input int d);
    logic [5:0] op;
    logic [31:0] r;
    case ($urandom_range(0, 13))
      0: op = LB;   1: op = LH;   2: op = LW;   3: op = LBU;  4: op = LHU;
      5: op = SB;   6: op = SH;   7: op = SW;   8: op = JAL;  9: op = BEQ;
      10: op = 6'h00; 11: op = 6'h08; 12: op = 6'h0F; default: op = 6'h22;
    endcase
    r = $urandom;
    if ($urandom_range(0, 3) != 0) r = r & 32'hFFFF_FF1F;
    if ($urandom_range(0, 1) == 0) r[1:0] = 2'b00;
    issue(d, op, r, $urandom, $urandom, bit'($urandom_range(0, 1)), "rand");
  endtask

  task automatic reset_midop();
    @(negedge clk);
    valid[0] = 1'b1; ins[0] = {SW, 26'h0}; result[0] = 32'h8;
    rdata2[0] = 32'h55; npc[0] = 32'h0;
    @(negedge clk);
    valid[0] = 1'b0;
    chk("midop.accepted", 32'(ready[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    chk("midop.ready", 32'(ready[0]), 32'd1);
    chk("midop.wdata", wdata[0], 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("midop.no_done", 32'(done[0]), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; ins[d] = '0; result[d] = '0; rdata2[d] = '0; npc[d] = '0;
    end
    model_clear();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset.ready", 32'(ready[d]), 32'd1);
      chk("reset.done", 32'(done[d]), 32'd0);
      chk("reset.fault", 32'(fault[d]), 32'd0);
      chk("reset.wdata", wdata[d], 32'h0);
    end
    rst = 1'b0;

    issue(0, SW,  32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, "sw_lat");
    issue(0, LW,  32'h10, 32'h0, 32'h0, 1'b0, "lw_lat");
    issue(0, SW,  32'h20, 32'h1122_3344, 32'h0, 1'b0, "sw20");
    issue(0, SB,  32'h21, 32'h0000_00AA, 32'h0, 1'b0, "sb21");
    issue(0, LW,  32'h20, 32'h0, 32'h0, 1'b0, "lw20");
    issue(0, LB,  32'h21, 32'h0, 32'h0, 1'b0, "lb21");
    issue(0, LBU, 32'h21, 32'h0, 32'h0, 1'b0, "lbu21");
    issue(0, LHU, 32'h22, 32'h0, 32'h0, 1'b0, "lhu22");
    issue(0, LH,  32'h20, 32'h0, 32'h0, 1'b0, "lh20");
    issue(0, LW,  32'h22, 32'h0, 32'h0, 1'b0, "lw_mis");
    issue(0, SH,  32'h23, 32'hBEEF, 32'h0, 1'b0, "sh_mis");
    issue(0, LW,  32'h20, 32'h0, 32'h0, 1'b0, "lw20_after_mis");
    issue(0, JAL, 32'h1234, 32'h0, 32'h400, 1'b1, "jal");
    issue(0, 6'h00, 32'h7, 32'h0, 32'h0, 1'b0, "add");
    issue(0, SW,  32'h100, 32'hCAFE_0001, 32'h0, 1'b1, "sw_wrap");
    issue(0, LW,  32'h000, 32'h0, 32'h0, 1'b0, "lw_wrap");
    issue(1, SH,  32'h2E, 32'h8001, 32'h0, 1'b0, "w0_sh");
    issue(1, LH,  32'h2E, 32'h0, 32'h0, 1'b1, "w0_lh");
    issue(1, JAL, 32'h0, 32'h0, 32'h404, 1'b0, "w0_jal");

    reset_midop();
    issue(0, LW, 32'h8, 32'h0, 32'h0, 1'b0, "lw_after_rst");
    issue(0, LW, 32'h10, 32'h0, 32'h0, 1'b0, "lw_cleared");

    for (int i = 0; i < 120; i++) rand_op(0);
    for (int i = 0; i < 200; i++) rand_op(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
